ad9361_spi_seq: RTL and testbench

// Command sequencer directly upstream of the AD9361 SPI shift core. Accepts single-byte

---
 rtl/ad9361_spi_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_ad9361_spi_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_spi_seq.sv
// Command sequencer for the AD9361 SPI shift core: queues byte read/write requests,
// runs the core's level start/done handshake with a CS-high gap, and returns read data.
module ad9361_spi_seq #(
    parameter int CMD_DEPTH  = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic        s_cmd_wr,
    input  logic [9:0]  s_cmd_addr,
    input  logic [7:0]  s_cmd_wdata,
    output logic        m_rsp_valid,
    input  logic        m_rsp_ready,
    output logic [9:0]  m_rsp_addr,
    output logic [7:0]  m_rsp_rdata,
    output logic        m_rsp_timeout,
    output logic [23:0] o_core_data,
    output logic        o_core_start,
    input  logic        i_core_done,
    input  logic [7:0]  i_core_rdata,
    output logic        o_busy,
    output logic        o_err_timeout
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(CMD_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RELEASE = 3'd2,
        GAP     = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [23:0]        core_data_q, core_data_d;
    logic               start_q, start_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               timed_out_q, timed_out_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [9:0]         rsp_addr_q, rsp_addr_d;
    logic [7:0]         rsp_rdata_q, rsp_rdata_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    // Entry layout: {wr, addr[9:0], wdata[7:0]}
    logic [18:0]        fifo_mem [CMD_DEPTH];
    logic [18:0]        head;
    logic               push;
    logic               pop;
    logic               cur_is_read;

    assign head        = fifo_mem[rd_ptr_q];
    assign push        = s_cmd_valid && ready_q;
    assign cur_is_read = !core_data_q[23];

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s_cmd_wr, s_cmd_addr, s_cmd_wdata};
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        core_data_d   = core_data_q;
        start_d       = 1'b0;
        timer_d       = timer_q;
        gap_d         = gap_q;
        timed_out_d   = timed_out_q;
        err_d         = err_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        pop           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    core_data_d = {head[18], 5'b00000, head[17:8],
                                   head[18] ? head[7:0] : 8'h00};
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                start_d = 1'b1;
                // Done and the timer are only meaningful once start is visible to the core.
                if (start_q) begin
                    if (i_core_done) begin
                        start_d = 1'b0;
                        if (cur_is_read) begin
                            rsp_addr_d    = core_data_q[17:8];
                            rsp_rdata_d   = i_core_rdata;
                            rsp_timeout_d = 1'b0;
                        end
                        state_d = RELEASE;
                    end else if (timer_q == TMR_LAST) begin
                        start_d     = 1'b0;
                        err_d       = 1'b1;
                        timed_out_d = 1'b1;
                        if (cur_is_read) begin
                            rsp_addr_d    = core_data_q[17:8];
                            rsp_rdata_d   = 8'h00;
                            rsp_timeout_d = 1'b1;
                        end
                        state_d = RELEASE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (timed_out_q || !i_core_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    rsp_valid_d = cur_is_read;
                    state_d     = cur_is_read ? RESP : IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            RESP: begin
                if (m_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d != DEPTH_C);
        busy_d  = (count_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            core_data_q   <= '0;
            start_q       <= 1'b0;
            timer_q       <= '0;
            gap_q         <= '0;
            timed_out_q   <= 1'b0;
            err_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            core_data_q   <= core_data_d;
            start_q       <= start_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            timed_out_q   <= timed_out_d;
            err_q         <= err_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign s_cmd_ready   = ready_q;
    assign m_rsp_valid   = rsp_valid_q;
    assign m_rsp_addr    = rsp_addr_q;
    assign m_rsp_rdata   = rsp_rdata_q;
    assign m_rsp_timeout = rsp_timeout_q;
    assign o_core_data   = core_data_q;
    assign o_core_start  = start_q;
    assign o_busy        = busy_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_ad9361_spi_seq.sv
// Bench for ad9361_spi_seq: behavioural SPI core model, command/response reference
// queues predicted at push time, and directed plus randomized command streams.
module tb_ad9361_spi_seq;
    localparam int CMD_DEPTH  = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic        s_cmd_wr = 1'b0;
    logic [9:0]  s_cmd_addr = '0;
    logic [7:0]  s_cmd_wdata = '0;
    logic        m_rsp_valid;
    logic        m_rsp_ready = 1'b1;
    logic [9:0]  m_rsp_addr;
    logic [7:0]  m_rsp_rdata;
    logic        m_rsp_timeout;
    logic [23:0] o_core_data;
    logic        o_core_start;
    logic        i_core_done = 1'b0;
    logic [7:0]  i_core_rdata = 8'h00;
    logic        o_busy;
    logic        o_err_timeout;

    ad9361_spi_seq #(
        .CMD_DEPTH(CMD_DEPTH),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_wr(s_cmd_wr),
        .s_cmd_addr(s_cmd_addr),
        .s_cmd_wdata(s_cmd_wdata),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready),
        .m_rsp_addr(m_rsp_addr),
        .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_timeout(m_rsp_timeout),
        .o_core_data(o_core_data),
        .o_core_start(o_core_start),
        .i_core_done(i_core_done),
        .i_core_rdata(i_core_rdata),
        .o_busy(o_busy),
        .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] word;
        bit          hang;
    } xfer_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] rdata;
        logic       tmo;
    } rsp_t;

    xfer_t      exp_q[$];
    rsp_t       rsp_exp_q[$];
    logic [7:0] core_regs [1024];
    logic [7:0] ref_regs  [1024];

    int checks = 0;
    int errors = 0;
    int push_stalls = 0;
    int core_lat = 4;
    bit rand_ready = 1'b0;

    // Core model / monitor state
    bit          prev_start = 1'b0;
    bit          had_xfer = 1'b0;
    bit          cur_hang = 1'b0;
    int          low_cnt = 0;
    int          busy_cnt = 0;
    logic [23:0] cur_word = '0;
    xfer_t       mon_x;
    rsp_t        mon_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_cmd(input bit wr, input logic [9:0] addr, input logic [7:0] wd,
                            input bit hang);
        xfer_t xe;
        rsp_t  re;
        bit    acc;
        int    n;
        xe.word = {wr, 5'b00000, addr, wr ? wd : 8'h00};
        xe.hang = hang;
        exp_q.push_back(xe);
        if (wr) begin
            if (!hang) ref_regs[addr] = wd;
        end else begin
            re.addr  = addr;
            re.rdata = hang ? 8'h00 : ref_regs[addr];
            re.tmo   = hang;
            rsp_exp_q.push_back(re);
        end
        s_cmd_valid = 1'b1;
        s_cmd_wr    = wr;
        s_cmd_addr  = addr;
        s_cmd_wdata = wd;
        n = 0;
        do begin
            acc = s_cmd_ready;
            tick();
            n++;
        end while (!acc && n < 1000);
        chk("push_accept", acc, 1);
        if (n > 1) push_stalls++;
        s_cmd_valid = 1'b0;
        $display("push wr=%0d addr=%03h wdata=%02h hang=%0d waited=%0d", wr, addr, wd, hang, n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_reached", n < 3000, 1);
    endtask

    task automatic wait_start();
        int n = 0;
        while (o_core_start !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("start_reached", n < 500, 1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (m_rsp_valid !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("rsp_reached", n < 500, 1);
    endtask

    // SPI core model and transaction monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (i_reset) begin
            i_core_done = 1'b0;
            prev_start  = 1'b0;
            had_xfer    = 1'b0;
            cur_hang    = 1'b0;
            low_cnt     = 0;
            busy_cnt    = 0;
        end else begin
            if (o_core_start && !prev_start) begin
                if (had_xfer) chk("start_gap", low_cnt >= GAP_CYCLES, 1);
                chk("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_x = exp_q.pop_front();
                    chk("core_word", o_core_data, mon_x.word);
                    cur_hang = mon_x.hang;
                end else begin
                    cur_hang = 1'b0;
                end
                $display("xfer word=%06h hang=%0d", o_core_data, cur_hang);
                cur_word = o_core_data;
                busy_cnt = 0;
                had_xfer = 1'b1;
            end else if (o_core_start) begin
                chk("word_stable", o_core_data, cur_word);
            end
            if (o_core_start && !i_core_done && !cur_hang) begin
                busy_cnt++;
                if (busy_cnt >= core_lat) begin
                    i_core_done = 1'b1;
                    if (cur_word[23]) begin
                        core_regs[cur_word[17:8]] = cur_word[7:0];
                        i_core_rdata = 8'($urandom);
                    end else begin
                        i_core_rdata = core_regs[cur_word[17:8]];
                    end
                end
            end else if (!o_core_start && i_core_done) begin
                i_core_done = 1'b0;
            end
            low_cnt = o_core_start ? 0 : low_cnt + 1;
            if (m_rsp_valid && m_rsp_ready) begin
                chk("rsp_expected", rsp_exp_q.size() != 0, 1);
                if (rsp_exp_q.size() != 0) begin
                    mon_r = rsp_exp_q.pop_front();
                    chk("rsp_addr", m_rsp_addr, mon_r.addr);
                    chk("rsp_rdata", m_rsp_rdata, mon_r.rdata);
                    chk("rsp_timeout", m_rsp_timeout, mon_r.tmo);
                end
                $display("rsp addr=%03h rdata=%02h timeout=%0d", m_rsp_addr, m_rsp_rdata, m_rsp_timeout);
            end
            prev_start = o_core_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0]  a;
        logic [9:0]  h_addr;
        logic [7:0]  h_rdata;
        logic        h_tmo;
        int          n;

        for (int i = 0; i < 1024; i++) begin
            core_regs[i] = 8'($urandom);
            ref_regs[i]  = core_regs[i];
        end

        // Reset state
        i_reset = 1'b1;
        repeat (3) tick();
        chk("rst_ready", s_cmd_ready, 1);
        chk("rst_rsp_valid", m_rsp_valid, 0);
        chk("rst_rsp_addr", m_rsp_addr, 0);
        chk("rst_rsp_rdata", m_rsp_rdata, 0);
        chk("rst_rsp_tmo", m_rsp_timeout, 0);
        chk("rst_core_data", o_core_data, 0);
        chk("rst_start", o_core_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err_timeout, 0);
        i_reset = 1'b0;
        tick();

        // 1) Write, latency of start from push
        core_lat = 4;
        push_cmd(1'b1, 10'h037, 8'hA5, 1'b0);
        chk("t1_start_p0", o_core_start, 0);
        tick();
        chk("t1_start_p1", o_core_start, 0);
        tick();
        chk("t1_start_p2", o_core_start, 1);
        chk("t1_word", o_core_data, 24'h8037A5);
        wait_idle();

        // 2) Read with known register contents
        core_regs[10'h017] = 8'h5C;
        ref_regs[10'h017]  = 8'h5C;
        push_cmd(1'b0, 10'h017, 8'hFF, 1'b0);
        wait_start();
        chk("t2_word", o_core_data, 24'h001700);
        wait_rsp();
        chk("t2_addr", m_rsp_addr, 10'h017);
        chk("t2_rdata", m_rsp_rdata, 8'h5C);
        chk("t2_tmo", m_rsp_timeout, 0);
        wait_idle();

        // 3) Five back-to-back commands against a slow core
        core_lat = 12;
        push_stalls = 0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom), 1'b0);
        end
        chk("t3_no_stall", push_stalls, 0);
        chk("t3_ready_full", s_cmd_ready, 0);
        wait_idle();
        chk("t3_xfers_done", exp_q.size(), 0);
        chk("t3_rsps_done", rsp_exp_q.size(), 0);

        // 4) Response back-pressure holds data and blocks the next transfer
        core_lat = 3;
        m_rsp_ready = 1'b0;
        push_cmd(1'b0, 10'($urandom), 8'h00, 1'b0);
        push_cmd(1'b1, 10'($urandom), 8'($urandom), 1'b0);
        wait_rsp();
        h_addr  = m_rsp_addr;
        h_rdata = m_rsp_rdata;
        h_tmo   = m_rsp_timeout;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_valid_hold", m_rsp_valid, 1);
            chk("t4_addr_hold", m_rsp_addr, h_addr);
            chk("t4_rdata_hold", m_rsp_rdata, h_rdata);
            chk("t4_tmo_hold", m_rsp_timeout, h_tmo);
            chk("t4_no_start", o_core_start, 0);
        end
        m_rsp_ready = 1'b1;
        tick();
        chk("t4_valid_clr", m_rsp_valid, 0);
        wait_idle();
        chk("t4_xfers_done", exp_q.size(), 0);

        // 5) Timed-out read, then sequencing resumes
        chk("t5_err_before", o_err_timeout, 0);
        a = 10'($urandom);
        push_cmd(1'b0, a, 8'h00, 1'b1);
        push_cmd(1'b1, 10'($urandom), 8'($urandom), 1'b0);
        push_cmd(1'b0, 10'($urandom), 8'h00, 1'b0);
        wait_start();
        n = 0;
        while (o_err_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", n, TIMEOUT);
        wait_rsp();
        chk("t5_rsp_addr", m_rsp_addr, a);
        chk("t5_rsp_rdata", m_rsp_rdata, 8'h00);
        chk("t5_rsp_tmo", m_rsp_timeout, 1);
        wait_idle();
        chk("t5_err_sticky", o_err_timeout, 1);
        chk("t5_xfers_done", exp_q.size(), 0);
        chk("t5_rsps_done", rsp_exp_q.size(), 0);

        // 6) Reset while a transfer is in progress with three queued
        core_lat = 50;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 10'($urandom), 8'h00, 1'b0);
        end
        wait_start();
        repeat (3) tick();
        chk("t6_start_pre", o_core_start, 1);
        i_reset = 1'b1;
        exp_q.delete();
        rsp_exp_q.delete();
        tick();
        chk("t6_start", o_core_start, 0);
        chk("t6_ready", s_cmd_ready, 1);
        chk("t6_busy", o_busy, 0);
        chk("t6_rsp_valid", m_rsp_valid, 0);
        chk("t6_err", o_err_timeout, 0);
        i_reset = 1'b0;
        repeat (8) tick();
        chk("t6_start_after", o_core_start, 0);
        chk("t6_busy_after", o_busy, 0);

        // 7) Randomized mix with random response back-pressure
        core_lat = int'($urandom_range(1, 6));
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push_cmd(1'($urandom_range(0, 1)), 10'($urandom), 8'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_idle();
        rand_ready = 1'b0;
        m_rsp_ready = 1'b1;
        tick();
        chk("t7_xfers_done", exp_q.size(), 0);
        chk("t7_rsps_done", rsp_exp_q.size(), 0);
        chk("t7_err_clear", o_err_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
